// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM states, mode encodings and one-hot decode for the 8-way arbiter
package arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_RELEASE
  } arb_state_e;
  localparam logic ARB_MODE_FIXED = 1'b0;
  localparam logic ARB_MODE_RR    = 1'b1;
  function automatic logic [2:0] oh2idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) idx = oh[i] ? (idx | 3'(i)) : idx;
    return idx;
  endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate requests so the pointer lands at bit 0, take the lowest set bit, rotate back
module rr_priority_pick (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  input  logic       rr,
  output logic       pick_valid,
  output logic [2:0] pick_id
);
  logic [2:0] p;
  logic [7:0] rot;
  logic [2:0] enc;
  assign p = rr ? ptr : 3'd0;
  always_comb begin
    rot = '0;
    enc = '0;
    for (int i = 0; i < 8; i++) rot[i] = req[p + 3'(i)];
    for (int i = 7; i >= 0; i--) enc = rot[i] ? 3'(i) : enc;
  end
  assign pick_valid = |req;
  assign pick_id    = enc + p;
endmodule

// File: rtl/arb_prio_rr8.sv
// arb_prio_rr8: eight-client fixed/round-robin arbiter with hold budget and one dead cycle between owners
module arb_prio_rr8 import arb_pkg::*; #(
  parameter int NUM_REQ  = 8,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               clear,
  input  logic               mode_rr,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         gnt_id,
  output logic               gnt_valid,
  output logic               preempt
);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  arb_state_e        state_q, state_d;
  logic [7:0]        gnt_q, gnt_d;
  logic [2:0]        gnt_id_q, gnt_id_d, ptr_q, ptr_d, pick_id;
  logic              gnt_valid_q, gnt_valid_d, preempt_q, preempt_d, pick_valid;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              owner_req, others_req, hold_exp;
  rr_priority_pick u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .rr        (mode_rr == ARB_MODE_RR),
    .pick_valid(pick_valid),
    .pick_id   (pick_id)
  );
  assign owner_req  = |(req & gnt_q);
  assign others_req = |(req & ~gnt_q);
  assign hold_exp   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    preempt_d = 1'b0;
    case (state_q)
      ST_IDLE: if (enable && pick_valid) begin
        state_d = ST_GRANT;
        gnt_d   = 8'b1 << pick_id;
        ptr_d   = pick_id + 3'd1;
        hold_d  = '0;
      end
      ST_GRANT: begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        // an owner dropping req on the expiry cycle is a normal release, not a preemption
        if (!owner_req || (hold_exp && others_req)) begin
          state_d   = ST_RELEASE;
          gnt_d     = '0;
          preempt_d = owner_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    gnt_id_d    = oh2idx(gnt_d);
    gnt_valid_d = |gnt_d;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      preempt_q   <= 1'b0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      preempt_q   <= preempt_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end
  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign preempt   = preempt_q;
endmodule

// File: tb/tb_arb_prio_rr8.sv
// tb_arb_prio_rr8: directed plan plus random traffic against an owner/cycle-count reference model
module tb_arb_prio_rr8;
  localparam int MH = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0, enable = 1'b1, clear = 1'b0, mode_rr = 1'b0;
  logic [7:0] req = 8'hFF;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid, preempt;
  int n_chk = 0, n_err = 0;
  int m_owner = -1, m_ptr = 0, m_held = 0;
  bit m_dead = 0, m_pre = 0;
  arb_prio_rr8 #(.NUM_REQ(8), .MAX_HOLD(MH), .HOLD_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .mode_rr(mode_rr),
    .req(req), .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .preempt(preempt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_tick();
    int base;
    m_pre = 0;
    if (!rst_n || clear) begin
      m_owner = -1; m_dead = 0; m_ptr = 0; m_held = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || (MH > 0 && m_held == MH && (req & ~(8'd1 << m_owner)) != 0)) begin
        m_pre = req[m_owner];
        m_owner = -1;
        m_dead = 1;
      end else m_held++;
    end else if (m_dead) m_dead = 0;
    else if (enable && req != 0) begin
      base = mode_rr ? m_ptr : 0;
      for (int k = 7; k >= 0; k--) if (req[(base + k) % 8]) m_owner = (base + k) % 8;
      m_ptr = (m_owner + 1) % 8;
      m_held = 1;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    chk("gnt", gnt, m_owner >= 0 ? 8'(1 << m_owner) : 8'h00);
    chk("gnt_id", 8'(gnt_id), m_owner >= 0 ? 8'(m_owner) : 8'h00);
    chk("gnt_valid", 8'(gnt_valid), 8'(m_owner >= 0));
    chk("preempt", 8'(preempt), 8'(m_pre));
  endtask
  task automatic do_clear();
    clear = 1'b1; step(); clear = 1'b0;
  endtask
  initial begin
    int cnt, g;
    bit seen;
    step(); step();
    chk("rst_gnt", gnt, 8'h00);
    rst_n = 1'b1; step();
    chk("rst_first", gnt, 8'h01);
    req = 8'b1010_0000; step(); step(); step();
    chk("fix_5", 8'(gnt_id), 8'd5);
    req = 8'h80; step();
    chk("fix_dead", gnt, 8'h00);
    step(); step();
    chk("fix_7", 8'(gnt_id), 8'd7);
    req = 8'h00; mode_rr = 1'b1; do_clear();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      g = 0;
      while (!gnt_valid && g < 10) begin step(); g++; end
      chk("rr_wait", 8'(g < 10), 8'd1);
      chk("rr_seq", 8'(gnt_id), 8'(k % 8));
      req = 8'hFF & ~gnt; step(); req = 8'hFF;
      chk("rr_dead", 8'(gnt_valid), 8'd0);
    end
    req = 8'h03; do_clear(); step();
    cnt = 0;
    while (gnt_valid && gnt_id == 3'd0 && cnt < 20) begin cnt++; step(); end
    chk("hold_len", 8'(cnt), 8'(MH));
    chk("preempt_pulse", 8'(preempt), 8'd1);
    step(); step();
    chk("after_pre", 8'(gnt_id), 8'd1);
    req = 8'h01; do_clear();
    seen = 0;
    for (int k = 0; k < 20; k++) begin step(); seen |= preempt; end
    chk("lone_nopre", 8'(seen), 8'd0);
    mode_rr = 1'b0; req = 8'h04; do_clear(); step();
    chk("en_grant", 8'(gnt_id), 8'd2);
    enable = 1'b0; step(); step(); step();
    chk("en_kept", gnt, 8'h04);
    req = 8'h00; step(); req = 8'h04;
    for (int k = 0; k < 4; k++) step();
    chk("en_blocked", 8'(gnt_valid), 8'd0);
    enable = 1'b1; step();
    mode_rr = 1'b1; req = 8'h08; do_clear(); step();
    chk("clr_pre", 8'(gnt_id), 8'd3);
    req = 8'hFF; do_clear();
    chk("clr_drop", gnt, 8'h00);
    step();
    chk("clr_ptr", gnt, 8'h01);
    for (int k = 0; k < 3000; k++) begin
      rst_n   = ($urandom_range(0, 299) != 0);
      clear   = ($urandom_range(0, 149) == 0);
      enable  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) mode_rr = ~mode_rr;
      if ($urandom_range(0, 2) == 0) req = req ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) req = 8'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/arb_prio_rr8.md
# arb_prio_rr8

Eight-requester arbiter sharing one resource port (bus master slot, encoder input lane, shared register-file write port) among eight clients. Selects a single owner with either fixed priority (index 0 highest) or round-robin, holds the grant until the owner releases or a hold budget expires, and reports the owner as a one-hot vector and a 3-bit index. Sits between the requesting clients and the shared datapath; the datapath mux is steered directly by `gnt_id` while `gnt_valid` is high.

## Interface
- `NUM_REQ`, 8: requester count; fixed at 8 for this block, and `gnt_id` is 3 bits.
- `MAX_HOLD`, 16: maximum consecutive grant cycles while another requester waits; 0 disables preemption.
- `HOLD_W`, 5: hold counter width; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  permits new grants; an existing grant is unaffected.
- `clear`  in  1  synchronous soft clear, same effect as reset, ignored while `rst_n`=0.
- `mode_rr`  in  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE.
- `req`  in  8  request vector, level, held by client until done.
- `gnt`  out  8  one-hot grant, registered.
- `gnt_id`  out  3  index of `gnt`; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  high iff `gnt` is nonzero.
- `preempt`  out  1  one-cycle pulse when a grant is revoked by the hold budget.

## Operation
- Reset or clear: state IDLE; `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0; RR pointer=0; hold counter=0.
- States IDLE, GRANT, RELEASE.
- IDLE: if `enable` and `|req`, pick a winner, register `gnt`/`gnt_id`, go to GRANT, clear hold counter. Otherwise stay in IDLE.
- Fixed pick: the lowest set index wins. RR pick: the first set index at or after the pointer, wrapping 7 to 0. On every grant to index i, the pointer becomes (i+1) mod 8, in both modes.
- GRANT: hold counter increments each cycle and saturates at MAX_HOLD.
  - If `req[owner]`=0, go to RELEASE.
  - Otherwise, if MAX_HOLD≠0, counter = MAX_HOLD-1 and any other `req` bit is set, go to RELEASE and pulse `preempt` with the transition.
  - Otherwise stay. A lone requester is never preempted.
- RELEASE: outputs zero for exactly one cycle (bus turnaround), then IDLE. There are never back-to-back grants without a dead cycle.
- Preempted owner keeps its `req` high and re-competes normally. In RR mode it now has the lowest priority.
- `enable` low in GRANT does not revoke the grant. The block just cannot leave IDLE while `enable`=0.
- `clear` and `rst_n` take effect at the next edge in any state, including mid-grant. The grant drops on that edge with no RELEASE cycle.
- `mode_rr` change during GRANT applies at the next IDLE pick.

## Timing
- Grant latency: `req` high at edge N with state IDLE gives `gnt` valid after edge N (visible cycle N+1).
- Release: `req[owner]` low sampled at edge N gives `gnt`=0 after N. The state is IDLE after N+1, and the next grant is visible after edge N+2.
- Preemption: the owner holds exactly MAX_HOLD cycles. `preempt` is high in the first RELEASE cycle.
- All outputs are registered. There is no combinational path from `req` to `gnt`.

## Structure
- Package `arb_pkg`:
  - State enum (IDLE, GRANT, RELEASE).
  - Constants `ARB_MODE_FIXED`=0 and `ARB_MODE_RR`=1.
  - Function onehot-to-index (3 bits).
- Sub-module `rr_priority_pick`: combinational, inputs `req[7:0]`, `ptr[2:0]`, `rr`; outputs `pick_valid`, `pick_id[2:0]`. Fixed mode forces ptr=0; RR uses a rotate-and-priority-encode scheme.
- Top holds the FSM, pointer, hold counter and output registers.

## Test plan
- Reset: `rst_n`=0 with `req`=8'hFF → all outputs 0. Release reset with `enable`=1, fixed mode → `gnt`=8'h01, `gnt_id`=0 one cycle later.
- Fixed priority: `req`=8'b1010_0000 → `gnt_id`=5. Drop bit 5 → one zero cycle, then `gnt_id`=7.
- Round-robin: `mode_rr`=1, `req`=8'hFF, each owner releases after 1 cycle → `gnt_id` sequence 0,1,2,…,7,0 with a dead cycle between grants.
- Preemption, MAX_HOLD=4: `req`=8'h03 held → `gnt_id`=0 for 4 cycles, then `preempt` pulse, then `gnt_id`=1 (RR). Same test with `req`=8'h01 only → no preempt.
- Enable/clear: grant on id 2, `enable`=0 → grant kept until release, then no new grant while `enable`=0. Assert `clear` mid-grant → `gnt`=0 next cycle, pointer reset, so the RR pick restarts at 0.
